// File: rtl/cp0_bus_master_pkg.sv
// Shared types and defaults for the CP0 register bus initiator.
package cp0_bus_master_pkg;

  // Default bus geometry: 32-bit data, 16 CP0 registers.
  localparam int CP0_DATA_SIZE_DEF = 32;
  localparam int CP0_ADDR_SIZE_DEF = 4;

  // Width of the shared wait/busy counter.
  localparam int CP0_TIMER_W = 8;

  // Sequencer state encodings.
  typedef enum logic [2:0] {
    CP0M_IDLE = 3'd0,
    CP0M_RD   = 3'd1,
    CP0M_WAIT = 3'd2,
    CP0M_WR   = 3'd3,
    CP0M_RESP = 3'd4
  } cp0m_state_t;

endpackage

// File: rtl/cp0_bus_master_if.sv
// Request/response handshake plus CP0 bus signals, seen from the initiator
// (master) or from the requester/bus side (slave).
interface cp0_bus_master_if
  import cp0_bus_master_pkg::*;
#(
  parameter int CP0_DATA_SIZE = CP0_DATA_SIZE_DEF,
  parameter int CP0_ADDR_SIZE = CP0_ADDR_SIZE_DEF
) ();

  // Request side (from the RSP scalar unit)
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [CP0_ADDR_SIZE-1:0] req_addr;
  logic [CP0_DATA_SIZE-1:0] req_wdata;

  // Response side
  logic                     rsp_valid;
  logic [CP0_DATA_SIZE-1:0] rsp_rdata;
  logic                     rsp_timeout;

  // CP0 register bus
  logic [CP0_ADDR_SIZE-1:0] cp0_address;
  logic                     cp0_read;
  logic                     cp0_write;
  logic [CP0_DATA_SIZE-1:0] cp0_wdata;
  logic                     cp0_wdata_en;
  logic [CP0_DATA_SIZE-1:0] cp0_data_in;
  logic                     cp0_busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, cp0_data_in, cp0_busy,
    output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
    output cp0_address, cp0_read, cp0_write, cp0_wdata, cp0_wdata_en
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, cp0_data_in, cp0_busy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
    input  cp0_address, cp0_read, cp0_write, cp0_wdata, cp0_wdata_en
  );

endinterface

// File: rtl/cp0_bus_timer.sv
// 8-bit cycle counter shared by the read-turnaround wait and the busy
// timeout. expire flags the cycle whose count equals 'last'.
module cp0_bus_timer
  import cp0_bus_master_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   clear,
  input  logic                   inc,
  input  logic [CP0_TIMER_W-1:0] last,
  output logic                   expire
);

  logic [CP0_TIMER_W-1:0] count_reg;

  // Count up while inc is high; clear wins so a new phase always starts at 0.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expire = (count_reg == last);

endmodule

// File: rtl/cp0_bus_master.sv
// Initiator for the shared CP0 register bus: takes one read/write request at
// a time, runs the strobe phase (stretched by cp0_busy, bounded by TIMEOUT),
// waits READ_LAT cycles for read data, and returns a single response pulse.
module cp0_bus_master
  import cp0_bus_master_pkg::*;
#(
  parameter int CP0_DATA_SIZE = CP0_DATA_SIZE_DEF,
  parameter int CP0_ADDR_SIZE = CP0_ADDR_SIZE_DEF,
  parameter int READ_LAT      = 1,   // 1..7
  parameter int TIMEOUT       = 64   // 2..255
) (
  input  logic                  clk,
  input  logic                  reset_l,
  cp0_bus_master_if.master      bus
);

  // Terminal counts: the wait phase ends on its READ_LAT-th cycle, the
  // strobe aborts on its TIMEOUT-th consecutive busy cycle.
  localparam logic [CP0_TIMER_W-1:0] READ_LAT_LAST = CP0_TIMER_W'(READ_LAT - 1);
  localparam logic [CP0_TIMER_W-1:0] TIMEOUT_LAST  = CP0_TIMER_W'(TIMEOUT - 1);

  cp0m_state_t state_reg, state_next;

  logic                     req_ready_reg,    req_ready_next;
  logic                     rsp_valid_reg,    rsp_valid_next;
  logic [CP0_DATA_SIZE-1:0] rsp_rdata_reg,    rsp_rdata_next;
  logic                     rsp_timeout_reg,  rsp_timeout_next;
  logic [CP0_ADDR_SIZE-1:0] cp0_address_reg,  cp0_address_next;
  logic                     cp0_read_reg,     cp0_read_next;
  logic                     cp0_write_reg,    cp0_write_next;
  logic [CP0_DATA_SIZE-1:0] cp0_wdata_reg,    cp0_wdata_next;
  logic                     cp0_wdata_en_reg, cp0_wdata_en_next;

  logic                   accept;
  logic                   timer_clear;
  logic                   timer_inc;
  logic                   timer_expire;
  logic [CP0_TIMER_W-1:0] timer_last;

  assign accept      = bus.req_valid && req_ready_reg;
  assign timer_last  = (state_reg == CP0M_WAIT) ? READ_LAT_LAST : TIMEOUT_LAST;
  // Any state change starts a fresh count, so both RD/WR and WAIT begin at 0.
  assign timer_clear = (state_next != state_reg);

  cp0_bus_timer u_timer (
    .clk     (clk),
    .reset_l (reset_l),
    .clear   (timer_clear),
    .inc     (timer_inc),
    .last    (timer_last),
    .expire  (timer_expire)
  );

  // Next-state logic; every output register is derived from the state being
  // entered so the bus and response pins come straight off flops.
  always_comb begin
    state_next       = state_reg;
    timer_inc        = 1'b0;
    rsp_rdata_next   = '0;
    rsp_timeout_next = 1'b0;
    cp0_address_next = cp0_address_reg;
    cp0_wdata_next   = cp0_wdata_reg;

    case (state_reg)
      CP0M_IDLE, CP0M_RESP: begin
        if (accept) begin
          cp0_address_next = bus.req_addr;
          if (bus.req_write) begin
            cp0_wdata_next = bus.req_wdata;
            state_next     = CP0M_WR;
          end else begin
            state_next     = CP0M_RD;
          end
        end else begin
          state_next = CP0M_IDLE;
        end
      end

      CP0M_RD, CP0M_WR: begin
        if (!bus.cp0_busy) begin
          // Reads move on to the turnaround; writes complete with zero data.
          state_next = (state_reg == CP0M_RD) ? CP0M_WAIT : CP0M_RESP;
        end else begin
          timer_inc = 1'b1;
          if (timer_expire) begin
            state_next       = CP0M_RESP;
            rsp_timeout_next = 1'b1;
            rsp_rdata_next   = '1;
          end
        end
      end

      CP0M_WAIT: begin
        // cp0_busy is deliberately ignored here: the slave already took the strobe.
        timer_inc = 1'b1;
        if (timer_expire) begin
          rsp_rdata_next = bus.cp0_data_in;
          state_next     = CP0M_RESP;
        end
      end

      default: state_next = CP0M_IDLE;
    endcase

    req_ready_next    = (state_next == CP0M_IDLE) || (state_next == CP0M_RESP);
    rsp_valid_next    = (state_next == CP0M_RESP);
    cp0_read_next     = (state_next == CP0M_RD);
    cp0_write_next    = (state_next == CP0M_WR);
    cp0_wdata_en_next = (state_next == CP0M_WR);
  end

  // State and output registers; reset drops strobes and tristate enable at once.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_reg        <= CP0M_IDLE;
      req_ready_reg    <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      rsp_rdata_reg    <= '0;
      rsp_timeout_reg  <= 1'b0;
      cp0_address_reg  <= '0;
      cp0_read_reg     <= 1'b0;
      cp0_write_reg    <= 1'b0;
      cp0_wdata_reg    <= '0;
      cp0_wdata_en_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      req_ready_reg    <= req_ready_next;
      rsp_valid_reg    <= rsp_valid_next;
      rsp_rdata_reg    <= rsp_rdata_next;
      rsp_timeout_reg  <= rsp_timeout_next;
      cp0_address_reg  <= cp0_address_next;
      cp0_read_reg     <= cp0_read_next;
      cp0_write_reg    <= cp0_write_next;
      cp0_wdata_reg    <= cp0_wdata_next;
      cp0_wdata_en_reg <= cp0_wdata_en_next;
    end
  end

  assign bus.req_ready    = req_ready_reg;
  assign bus.rsp_valid    = rsp_valid_reg;
  assign bus.rsp_rdata    = rsp_rdata_reg;
  assign bus.rsp_timeout  = rsp_timeout_reg;
  assign bus.cp0_address  = cp0_address_reg;
  assign bus.cp0_read     = cp0_read_reg;
  assign bus.cp0_write    = cp0_write_reg;
  assign bus.cp0_wdata    = cp0_wdata_reg;
  assign bus.cp0_wdata_en = cp0_wdata_en_reg;

endmodule

// File: tb/tb_cp0_bus_master.sv
// Directed bench for cp0_bus_master: reset, read, busy write, read timeout,
// back-to-back write/read, and reset during a busy write.
module tb_cp0_bus_master;

  logic clk = 1'b0;
  logic reset_l = 1'b1;
  int   tests = 0;
  int   fails = 0;

  cp0_bus_master_if bus_if ();

  cp0_bus_master #(
    .CP0_DATA_SIZE (32),
    .CP0_ADDR_SIZE (4),
    .READ_LAT      (1),
    .TIMEOUT       (64)
  ) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Safety net in case something stalls the directed sequence.
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish by 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  hi;
    bit  seen;

    // ---------------- reset with req_valid high ----------------
    bus_if.req_valid   = 1'b1;
    bus_if.req_write   = 1'b1;
    bus_if.req_addr    = 4'h3;
    bus_if.req_wdata   = 32'h55AA_55AA;
    bus_if.cp0_data_in = 32'hDEAD_0000;
    bus_if.cp0_busy    = 1'b0;
    #1 reset_l = 1'b0;
    #1;
    chk1 ("rst_ready",    bus_if.req_ready,    1'b0);
    chk1 ("rst_rsp",      bus_if.rsp_valid,    1'b0);
    chk1 ("rst_read",     bus_if.cp0_read,     1'b0);
    chk1 ("rst_write",    bus_if.cp0_write,    1'b0);
    chk1 ("rst_wen",      bus_if.cp0_wdata_en, 1'b0);
    chk32("rst_rdata",    bus_if.rsp_rdata,    32'h0);
    repeat (2) cyc();
    chk1 ("rst_hold_ready", bus_if.req_ready, 1'b0);
    chk1 ("rst_hold_write", bus_if.cp0_write, 1'b0);
    bus_if.req_valid = 1'b0;
    reset_l = 1'b1;
    cyc();
    chk1 ("post_rst_ready", bus_if.req_ready, 1'b1);
    chk1 ("post_rst_read",  bus_if.cp0_read,  1'b0);
    chk1 ("post_rst_write", bus_if.cp0_write, 1'b0);
    cyc();
    chk1 ("idle_read",  bus_if.cp0_read,  1'b0);
    chk1 ("idle_write", bus_if.cp0_write, 1'b0);
    $display("[TB] reset: ready=%0b", bus_if.req_ready);

    // ---------------- read addr 5, READ_LAT=1 ----------------
    bus_if.req_valid   = 1'b1;
    bus_if.req_write   = 1'b0;
    bus_if.req_addr    = 4'h5;
    bus_if.cp0_data_in = 32'hDEAD_0001;
    cyc();  // cycle 1
    chk1 ("rd_c1_read",  bus_if.cp0_read,  1'b1);
    chk1 ("rd_c1_write", bus_if.cp0_write, 1'b0);
    chk1 ("rd_c1_ready", bus_if.req_ready, 1'b0);
    chk32("rd_c1_addr",  32'(bus_if.cp0_address), 32'h5);
    bus_if.req_valid = 1'b0;
    cyc();  // cycle 2: turnaround
    chk1 ("rd_c2_read", bus_if.cp0_read,  1'b0);
    chk1 ("rd_c2_rsp",  bus_if.rsp_valid, 1'b0);
    bus_if.cp0_data_in = 32'h1234_5678;
    cyc();  // cycle 3: response
    chk1 ("rd_c3_rsp",     bus_if.rsp_valid,   1'b1);
    chk32("rd_c3_rdata",   bus_if.rsp_rdata,   32'h1234_5678);
    chk1 ("rd_c3_timeout", bus_if.rsp_timeout, 1'b0);
    chk1 ("rd_c3_ready",   bus_if.req_ready,   1'b1);
    $display("[TB] read addr=5 rdata=%08h timeout=%0b", bus_if.rsp_rdata, bus_if.rsp_timeout);
    bus_if.cp0_data_in = 32'hDEAD_0002;
    cyc();
    chk1 ("rd_c4_rsp", bus_if.rsp_valid, 1'b0);

    // ---------------- write addr A, busy 3 cycles ----------------
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b1;
    bus_if.req_addr  = 4'hA;
    bus_if.req_wdata = 32'hCAFE_F00D;
    bus_if.cp0_busy  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk1($sformatf("wr_c%0d_write", i), bus_if.cp0_write,    1'b1);
      chk1($sformatf("wr_c%0d_wen", i),   bus_if.cp0_wdata_en, 1'b1);
      chk1($sformatf("wr_c%0d_read", i),  bus_if.cp0_read,     1'b0);
      chk1($sformatf("wr_c%0d_rsp", i),   bus_if.rsp_valid,    1'b0);
      if (i == 1) begin
        chk32("wr_wdata", bus_if.cp0_wdata, 32'hCAFE_F00D);
        chk32("wr_addr",  32'(bus_if.cp0_address), 32'hA);
        bus_if.req_valid = 1'b0;
      end
      if (i == 4) bus_if.cp0_busy = 1'b0;
    end
    cyc();  // cycle 5
    chk1 ("wr_c5_rsp",     bus_if.rsp_valid,    1'b1);
    chk32("wr_c5_rdata",   bus_if.rsp_rdata,    32'h0);
    chk1 ("wr_c5_timeout", bus_if.rsp_timeout,  1'b0);
    chk1 ("wr_c5_write",   bus_if.cp0_write,    1'b0);
    chk1 ("wr_c5_wen",     bus_if.cp0_wdata_en, 1'b0);
    $display("[TB] write addr=a wdata=cafef00d busy=3 rdata=%08h", bus_if.rsp_rdata);
    cyc();

    // ---------------- read timeout, busy stuck ----------------
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 4'h7;
    bus_if.cp0_busy  = 1'b1;
    hi   = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cyc();
      if (i == 0) bus_if.req_valid = 1'b0;
      if (bus_if.rsp_valid) seen = 1'b1;
      else if (bus_if.cp0_read) hi++;
    end
    chk1 ("to_rsp_seen", seen, 1'b1);
    chk32("to_read_cycles", hi, 32'd64);
    chk1 ("to_timeout", bus_if.rsp_timeout, 1'b1);
    chk32("to_rdata",   bus_if.rsp_rdata,   32'hFFFF_FFFF);
    chk1 ("to_read_low", bus_if.cp0_read,   1'b0);
    $display("[TB] read addr=7 busy stuck: strobe cycles=%0d timeout=%0b rdata=%08h",
             hi, bus_if.rsp_timeout, bus_if.rsp_rdata);
    bus_if.cp0_busy = 1'b0;

    // next request after timeout: accepted from the RESP cycle
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b1;
    bus_if.req_addr  = 4'h2;
    bus_if.req_wdata = 32'h0000_BEEF;
    cyc();
    chk1 ("post_to_write", bus_if.cp0_write, 1'b1);
    chk32("post_to_wdata", bus_if.cp0_wdata, 32'h0000_BEEF);
    chk32("post_to_addr",  32'(bus_if.cp0_address), 32'h2);
    bus_if.req_valid = 1'b0;
    cyc();
    chk1 ("post_to_rsp",     bus_if.rsp_valid,   1'b1);
    chk1 ("post_to_timeout", bus_if.rsp_timeout, 1'b0);
    chk32("post_to_rdata",   bus_if.rsp_rdata,   32'h0);
    $display("[TB] write addr=2 wdata=0000beef after timeout timeout=%0b", bus_if.rsp_timeout);
    cyc();

    // ---------------- back-to-back write then read ----------------
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b1;
    bus_if.req_addr  = 4'h1;
    bus_if.req_wdata = 32'h1111_1111;
    cyc();  // cycle 1: WR
    chk1("b2b_c1_write", bus_if.cp0_write, 1'b1);
    chk1("b2b_c1_read",  bus_if.cp0_read,  1'b0);
    chk1("b2b_c1_ready", bus_if.req_ready, 1'b0);
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 4'h9;
    cyc();  // cycle 2: RESP, second accept here
    chk1 ("b2b_c2_rsp",   bus_if.rsp_valid, 1'b1);
    chk1 ("b2b_c2_ready", bus_if.req_ready, 1'b1);
    chk1 ("b2b_c2_read",  bus_if.cp0_read,  1'b0);
    chk1 ("b2b_c2_write", bus_if.cp0_write, 1'b0);
    chk32("b2b_c2_rdata", bus_if.rsp_rdata, 32'h0);
    $display("[TB] b2b write addr=1 wdata=11111111 rsp=%0b", bus_if.rsp_valid);
    cyc();  // cycle 3: RD with no idle gap
    chk1 ("b2b_c3_read",  bus_if.cp0_read,  1'b1);
    chk1 ("b2b_c3_write", bus_if.cp0_write, 1'b0);
    chk1 ("b2b_c3_rsp",   bus_if.rsp_valid, 1'b0);
    chk32("b2b_c3_addr",  32'(bus_if.cp0_address), 32'h9);
    bus_if.req_valid = 1'b0;
    cyc();  // cycle 4: turnaround
    chk1("b2b_c4_read", bus_if.cp0_read, 1'b0);
    bus_if.cp0_data_in = 32'hA5A5_0F0F;
    cyc();  // cycle 5: read response
    chk1 ("b2b_c5_rsp",   bus_if.rsp_valid, 1'b1);
    chk32("b2b_c5_rdata", bus_if.rsp_rdata, 32'hA5A5_0F0F);
    $display("[TB] b2b read addr=9 rdata=%08h", bus_if.rsp_rdata);
    bus_if.cp0_data_in = 32'hDEAD_0003;
    cyc();

    // ---------------- reset during a busy write ----------------
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b1;
    bus_if.req_addr  = 4'h4;
    bus_if.req_wdata = 32'hDEAD_BEEF;
    bus_if.cp0_busy  = 1'b1;
    cyc();
    chk1("arst_c1_write", bus_if.cp0_write,    1'b1);
    chk1("arst_c1_wen",   bus_if.cp0_wdata_en, 1'b1);
    bus_if.req_valid = 1'b0;
    cyc();
    chk1("arst_c2_write", bus_if.cp0_write, 1'b1);
    #1 reset_l = 1'b0;
    #1;  // still well before the next rising edge
    chk1("arst_write_async", bus_if.cp0_write,    1'b0);
    chk1("arst_wen_async",   bus_if.cp0_wdata_en, 1'b0);
    chk1("arst_ready_async", bus_if.req_ready,    1'b0);
    cyc();
    bus_if.cp0_busy = 1'b0;
    reset_l = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus_if.rsp_valid) seen = 1'b1;
    end
    chk1("arst_no_rsp",  seen,              1'b0);
    chk1("arst_ready",   bus_if.req_ready,  1'b1);
    chk1("arst_write",   bus_if.cp0_write,  1'b0);
    $display("[TB] write addr=4 aborted by reset rsp_seen=%0b", seen);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
